// File: rtl/bcd_count_4digit_if.sv
// rtl/bcd_count_4digit_if.sv - control and digit bundle between the BCD counter and its user
interface bcd_count_4digit_if;
  logic        en;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        tick;
  logic        wrap;
  logic [3:0]  blank;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  digits, tick, wrap, blank
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output digits, tick, wrap, blank
  );
endinterface

// File: rtl/bcd_count_4digit.sv
// rtl/bcd_count_4digit.sv - prescaled 4-digit BCD up/down counter with tick/wrap strobes
// Optional leading-zero blank mask enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_count_4digit #(
  parameter int CLK_RATE = 100_000_000,
  parameter int TICK_HZ  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_count_4digit_if.slave bus
);

  localparam int DIV = CLK_RATE / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("bcd_count_4digit: CLK_RATE/TICK_HZ must be >= 2");
  end

  logic [PW-1:0] pre;
  logic [15:0]   digits_q;
  logic [15:0]   stepped;
  logic [15:0]   loaded;
  logic          tick_q;
  logic          wrap_q;
  logic          step;
  logic          roll;

  assign step = bus.en && (pre == PRE_MAX);

  // Ripple carry/borrow across digits; roll is set only when every digit rolled over.
  always_comb begin
    logic       c;
    logic [3:0] d;
    c       = 1'b1;
    d       = 4'd0;
    stepped = 16'h0000;
    loaded  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = digits_q[4*i +: 4];
      if (!c) begin
        stepped[4*i +: 4] = d;
      end else if (bus.up_dn) begin
        stepped[4*i +: 4] = (d == 4'd9) ? 4'd0 : 4'(d + 4'd1);
        c = (d == 4'd9);
      end else begin
        stepped[4*i +: 4] = (d == 4'd0) ? 4'd9 : 4'(d - 4'd1);
        c = (d == 4'd0);
      end
      loaded[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
    end
    roll = c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre      <= '0;
      digits_q <= 16'h0000;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (bus.clr) begin
      pre      <= '0;
      digits_q <= 16'h0000;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      if (bus.en) begin
        pre <= step ? '0 : pre + 1'b1;
      end
      // A load on a step edge still strobes tick but replaces the stepped value.
      tick_q <= step;
      wrap_q <= step && !bus.load && roll;
      if (bus.load) begin
        digits_q <= loaded;
      end else if (step) begin
        digits_q <= stepped;
      end
    end
  end

  assign bus.digits = digits_q;
  assign bus.tick   = tick_q;
  assign bus.wrap   = wrap_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign bus.blank[3] = (digits_q[15:12] == 4'd0);
  assign bus.blank[2] = bus.blank[3] && (digits_q[11:8] == 4'd0);
  assign bus.blank[1] = bus.blank[2] && (digits_q[7:4] == 4'd0);
  assign bus.blank[0] = 1'b0;
`else
  assign bus.blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bcd_count_4digit.sv
// tb/tb_bcd_count_4digit.sv - vector table, corner sequences and random run against a decimal model
module tb_bcd_count_4digit;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_count_4digit_if bus ();

  bcd_count_4digit #(.CLK_RATE(20), .TICK_HZ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_val, m_pre, n_tick, n_wrap;
  bit m_tick, m_wrap;

  typedef struct {
    logic [15:0] lv;
    bit          up;
    int          n;
    logic [15:0] ed;
    int          et;
    int          ew;
  } vec_t;
  vec_t vecs[10];

  function automatic int bcd2int(logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int nib = int'(b[4*i +: 4]);
      v += ((nib > 9) ? 0 : nib) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(int v);
    logic [15:0] b = 16'h0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return b;
  endfunction

  function automatic logic [3:0] exp_blank(int v);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    return {v < 1000, v < 100, v < 10, 1'b0};
`else
    return 4'b0000 & 4'(v);
`endif
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model();
    bit st;
    if (!rst_n || bus.clr) begin
      m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
    end else begin
      st = bus.en && (m_pre == DIV - 1);
      if (bus.en) m_pre = st ? 0 : m_pre + 1;
      m_tick = st;
      m_wrap = 0;
      if (bus.load) m_val = bcd2int(bus.load_val);
      else if (st && bus.up_dn) begin
        m_wrap = (m_val == 9999);
        m_val  = (m_val + 1) % 10000;
      end else if (st) begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + 9999) % 10000;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model();
    @(negedge clk);
    check("digits", bus.digits, int2bcd(m_val));
    check("tick", bus.tick, m_tick);
    check("wrap", bus.wrap, m_wrap);
    check("blank", bus.blank, exp_blank(m_val));
    if (bus.tick) n_tick++;
    if (bus.wrap) n_wrap++;
  endtask

  task automatic idle();
    bus.en = 0; bus.clr = 0; bus.load = 0; bus.load_val = 16'h0;
  endtask

  task automatic run_en(int n);
    bus.en = 1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    vecs[0] = '{16'h9998, 1, 10, 16'h9999, 1, 0};
    vecs[1] = '{16'h9998, 1, 20, 16'h0000, 2, 1};
    vecs[2] = '{16'h1000, 0, 10, 16'h0999, 1, 0};
    vecs[3] = '{16'h0000, 0, 10, 16'h9999, 1, 1};
    vecs[4] = '{16'h0009, 1, 10, 16'h0010, 1, 0};
    vecs[5] = '{16'h0990, 0, 10, 16'h0989, 1, 0};
    vecs[6] = '{16'h0999, 1, 30, 16'h1002, 3, 0};
    vecs[7] = '{16'h12A4, 1, 10, 16'h1205, 1, 0};
    vecs[8] = '{16'hFFFF, 0, 10, 16'h9999, 1, 1};
    vecs[9] = '{16'h9999, 1,  9, 16'h9999, 0, 0};

    // Reset held 3 cycles, then period check.
    idle(); bus.up_dn = 1; rst_n = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_digits", bus.digits, 16'h0000);
    check("reset_tick", bus.tick, 0);
    check("reset_blank", bus.blank, exp_blank(0));
    rst_n = 1; bus.en = 1;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      check("period_tick", bus.tick, (c % 10) == 0);
      if (c == 10) check("first_tick_digits", bus.digits, 16'h0001);
    end
    check("period_wrap", n_wrap, 0);

    // Table vectors: clear, load, then run a fixed number of enabled cycles.
    foreach (vecs[k]) begin
      idle(); bus.clr = 1; cycle();
      idle(); bus.up_dn = vecs[k].up; bus.load = 1; bus.load_val = vecs[k].lv; cycle();
      bus.load = 0; n_tick = 0; n_wrap = 0;
      run_en(vecs[k].n);
      check("vec_digits", bus.digits, vecs[k].ed);
      check("vec_ticks", n_tick, vecs[k].et);
      check("vec_wraps", n_wrap, vecs[k].ew);
    end

    // clr+load on a step edge, then load of an invalid nibble on the next step edge.
    idle(); bus.clr = 1; cycle(); idle(); bus.up_dn = 1;
    run_en(9);
    bus.clr = 1; bus.load = 1; bus.load_val = 16'h1234; cycle();
    check("coll_clr_digits", bus.digits, 16'h0000);
    check("coll_clr_tick", bus.tick, 0);
    bus.clr = 0; bus.load = 0;
    run_en(9);
    bus.load = 1; bus.load_val = 16'h12A4; cycle();
    check("coll_load_digits", bus.digits, 16'h1204);
    check("coll_load_tick", bus.tick, 1);
    check("coll_load_wrap", bus.wrap, 0);
    bus.load = 0;

    // en freeze at prescaler 4 for 7 cycles.
    idle(); bus.clr = 1; cycle(); idle();
    run_en(4);
    bus.en = 0; n_tick = 0;
    for (int i = 0; i < 7; i++) cycle();
    check("freeze_ticks", n_tick, 0);
    check("freeze_digits", bus.digits, 16'h0000);
    bus.en = 1;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      check("resume_tick", bus.tick, c == 6);
    end

    // Blank mask on fixed values.
    idle();
    bus.load = 1; bus.load_val = 16'h0042; cycle();
`ifdef BCD_LEADING_ZERO_BLANK_EN
    check("blank_0042", bus.blank, 4'b1100);
    bus.load_val = 16'h0000; cycle(); check("blank_0000", bus.blank, 4'b1110);
    bus.load_val = 16'h0100; cycle(); check("blank_0100", bus.blank, 4'b1000);
`else
    check("blank_0042", bus.blank, 4'b0000);
    bus.load_val = 16'h0000; cycle(); check("blank_0000", bus.blank, 4'b0000);
    bus.load_val = 16'h0100; cycle(); check("blank_0100", bus.blank, 4'b0000);
`endif
    bus.load = 0;

    // Randomized run against the decimal model.
    for (int i = 0; i < 800; i++) begin
      rst_n      = ($urandom_range(199) != 0);
      bus.en     = ($urandom_range(9) < 8);
      bus.clr    = ($urandom_range(79) == 0);
      bus.load   = ($urandom_range(29) == 0);
      if ($urandom_range(19) == 0) bus.up_dn = ~bus.up_dn;
      case ($urandom_range(3))
        0: bus.load_val = 16'h9999;
        1: bus.load_val = 16'h0000;
        default: bus.load_val = 16'($urandom);
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
